// File: rtl/neuro_lif_array.sv
// Leaky-integrate-and-fire layer engine.
// One timestep per input handshake: each set input spike adds its weight column to
// every non-refractory neuron (one input channel per cycle). The neurons then leak
// toward zero and fire against a threshold. The fired-neuron vector is held on a
// valid/ready output until it is accepted. An 8-bit CPU register port provides
// configuration and weight access.
module neuro_lif_array #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 8,
  parameter int V_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       cpu_addr,
  input  logic             cpu_we,
  input  logic             cpu_re,
  input  logic [7:0]       cpu_wdata,
  output logic [7:0]       cpu_rdata,
  output logic             cpu_ready,
  input  logic [N_IN-1:0]  in_spikes,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N_OUT-1:0] out_spikes,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      step_count,
  output logic [31:0]      spike_count,
  output logic [31:0]      idle_cycles
);

  localparam int JW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FIRE, S_OUT} state_t;

  state_t                r_state;
  logic                  r_en;
  logic [7:0]            r_th, r_lk, r_rf;
  logic [7:0]            r_th_s, r_lk_s, r_rf_s;
  logic [7:0]            r_wsel_in, r_wsel_out;
  logic                  r_wr_err;
  logic [7:0]            r_rdata;
  logic                  r_ready;
  logic signed [7:0]     r_w [N_OUT][N_IN];
  logic signed [V_W-1:0] r_v [N_OUT];
  logic [7:0]            r_rc [N_OUT];
  logic [N_IN-1:0]       r_spk;
  logic [JW-1:0]         r_j;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [N_OUT-1:0]      r_out_spikes;
  logic [31:0]           r_step, r_spk_cnt, r_idle;

  logic                  w_busy;
  logic                  w_en_nxt;
  logic                  w_idle_nxt;
  logic                  w_clr;
  logic                  w_wsel_ok;
  logic [JW-1:0]         w_ii;
  logic [OW-1:0]         w_oi;
  logic [7:0]            w_rdata;
  logic [32:0]           w_spk_sum;
  logic signed [V_W-1:0] w_th;
  logic signed [V_W-1:0] w_v_acc [N_OUT];
  logic signed [V_W-1:0] w_v_lk  [N_OUT];
  logic [N_OUT-1:0]      w_fire;

  // Add a signed 8-bit weight to a membrane, clamping at the signed V_W range.
  function automatic logic signed [V_W-1:0] sat_add(input logic signed [V_W-1:0] a,
                                                    input logic signed [7:0] b);
    logic signed [V_W:0] s;
    s = {a[V_W-1], a} + {{(V_W-7){b[7]}}, b};
    if (s[V_W] != s[V_W-1])
      return s[V_W] ? {1'b1, {(V_W-1){1'b0}}} : {1'b0, {(V_W-1){1'b1}}};
    return s[V_W-1:0];
  endfunction

  // Move a membrane toward zero by lk, never crossing zero.
  function automatic logic signed [V_W-1:0] leak_v(input logic signed [V_W-1:0] v,
                                                   input logic [7:0] lk);
    logic signed [V_W:0] ve, le, t;
    ve = {v[V_W-1], v};
    le = {{(V_W-7){1'b0}}, lk};
    if (v[V_W-1]) begin
      t = ve + le;
      return t[V_W] ? t[V_W-1:0] : '0;
    end
    t = ve - le;
    return t[V_W] ? '0 : t[V_W-1:0];
  endfunction

  function automatic logic [7:0] popcnt(input logic [N_OUT-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int k = 0; k < N_OUT; k++) c = c + {7'd0, v[k]};
    return c;
  endfunction

  assign w_busy     = (r_state != S_IDLE);
  assign w_en_nxt   = (cpu_we && cpu_addr == 8'h00) ? cpu_wdata[0] : r_en;
  assign w_clr      = cpu_we && (cpu_addr == 8'h00) && cpu_wdata[1] && !w_busy;
  assign w_idle_nxt = ((r_state == S_IDLE) && !(in_valid && r_in_ready)) ||
                      ((r_state == S_OUT) && out_ready);
  assign w_wsel_ok  = (r_wsel_in < 8'(N_IN)) && (r_wsel_out < 8'(N_OUT));
  assign w_ii       = r_wsel_in[JW-1:0];
  assign w_oi       = r_wsel_out[OW-1:0];
  assign w_spk_sum  = {1'b0, r_spk_cnt} + {25'd0, popcnt(r_out_spikes)};

  // Per-neuron next values: accumulate for the current channel, and leak/fire decision.
  always_comb begin
    w_th   = {{(V_W-8){1'b0}}, r_th_s};
    w_fire = '0;
    for (int i = 0; i < N_OUT; i++) begin
      w_v_acc[i] = r_v[i];
      if (r_spk[r_j] && r_rc[i] == 8'd0) w_v_acc[i] = sat_add(r_v[i], r_w[i][r_j]);
      w_v_lk[i]  = leak_v(r_v[i], r_lk_s);
      w_fire[i]  = (r_rc[i] == 8'd0) && (w_v_lk[i] >= w_th);
    end
  end

  // CPU read mux; reads reflect register state before any same-cycle write.
  always_comb begin
    w_rdata = 8'd0;
    case (cpu_addr)
      8'h00:   w_rdata = {7'd0, r_en};
      8'h01:   w_rdata = {5'd0, r_wr_err, r_out_valid, w_busy};
      8'h02:   w_rdata = r_th;
      8'h03:   w_rdata = r_lk;
      8'h04:   w_rdata = r_rf;
      8'h05:   w_rdata = r_wsel_in;
      8'h06:   w_rdata = r_wsel_out;
      8'h07:   w_rdata = w_wsel_ok ? r_w[w_oi][w_ii] : 8'd0;
      default: w_rdata = 8'd0;
    endcase
  end

  // CPU register file and weight memory with auto-incrementing write pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en       <= 1'b0;
      r_th       <= 8'd200;
      r_lk       <= 8'd1;
      r_rf       <= 8'd0;
      r_wsel_in  <= 8'd0;
      r_wsel_out <= 8'd0;
      r_wr_err   <= 1'b0;
      r_rdata    <= 8'd0;
      r_ready    <= 1'b0;
      for (int i = 0; i < N_OUT; i++)
        for (int k = 0; k < N_IN; k++) r_w[i][k] <= '0;
    end else begin
      r_ready <= cpu_we | cpu_re;
      if (cpu_re) begin
        r_rdata <= w_rdata;
        if (cpu_addr == 8'h01) r_wr_err <= 1'b0;
      end
      if (cpu_we) begin
        case (cpu_addr)
          8'h00: begin
            r_en <= cpu_wdata[0];
            if (cpu_wdata[1] && w_busy) r_wr_err <= 1'b1;
          end
          8'h02: r_th       <= cpu_wdata;
          8'h03: r_lk       <= cpu_wdata;
          8'h04: r_rf       <= cpu_wdata;
          8'h05: r_wsel_in  <= cpu_wdata;
          8'h06: r_wsel_out <= cpu_wdata;
          8'h07: begin
            if (w_busy) begin
              r_wr_err <= 1'b1;
            end else if (w_wsel_ok) begin
              r_w[w_oi][w_ii] <= cpu_wdata;
              if (r_wsel_in == 8'(N_IN - 1)) begin
                r_wsel_in  <= 8'd0;
                r_wsel_out <= (r_wsel_out == 8'(N_OUT - 1)) ? 8'd0 : r_wsel_out + 8'd1;
              end else begin
                r_wsel_in <= r_wsel_in + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Timestep FSM: IDLE -> ACCUM (one channel per cycle) -> FIRE -> OUT -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_j          <= '0;
      r_spk        <= '0;
      r_th_s       <= 8'd0;
      r_lk_s       <= 8'd0;
      r_rf_s       <= 8'd0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_spikes <= '0;
      r_step       <= 32'd0;
      r_spk_cnt    <= 32'd0;
      r_idle       <= 32'd0;
      for (int i = 0; i < N_OUT; i++) begin
        r_v[i]  <= '0;
        r_rc[i] <= 8'd0;
      end
    end else begin
      r_in_ready <= w_idle_nxt && w_en_nxt;
      if (r_state == S_IDLE) r_idle <= r_idle + 32'd1;
      unique case (r_state)
        S_IDLE: begin
          if (w_clr) begin
            for (int i = 0; i < N_OUT; i++) begin
              r_v[i]  <= '0;
              r_rc[i] <= 8'd0;
            end
          end
          if (in_valid && r_in_ready) begin
            r_spk   <= in_spikes;
            r_th_s  <= r_th;
            r_lk_s  <= r_lk;
            r_rf_s  <= r_rf;
            r_j     <= '0;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          for (int i = 0; i < N_OUT; i++) r_v[i] <= w_v_acc[i];
          if (r_j == JW'(N_IN - 1)) r_state <= S_FIRE;
          else                      r_j     <= r_j + 1'b1;
        end
        S_FIRE: begin
          for (int i = 0; i < N_OUT; i++) begin
            if (r_rc[i] != 8'd0) begin
              r_rc[i] <= r_rc[i] - 8'd1;
            end else if (w_fire[i]) begin
              r_v[i]  <= '0;
              r_rc[i] <= r_rf_s;
            end else begin
              r_v[i]  <= w_v_lk[i];
            end
          end
          r_out_spikes <= w_fire;
          r_out_valid  <= 1'b1;
          r_state      <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_step      <= r_step + 32'd1;
            r_spk_cnt   <= w_spk_sum[32] ? 32'hFFFF_FFFF : w_spk_sum[31:0];
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_rdata   = r_rdata;
  assign cpu_ready   = r_ready;
  assign in_ready    = r_in_ready;
  assign out_spikes  = r_out_spikes;
  assign out_valid   = r_out_valid;
  assign step_count  = r_step;
  assign spike_count = r_spk_cnt;
  assign idle_cycles = r_idle;

endmodule

// File: tb/tb_neuro_lif_array.sv
// Bench for neuro_lif_array: directed stimulus with queued expected responses,
// checked by a monitor whenever the DUT presents read data or an output vector.
module tb_neuro_lif_array;
  localparam int N_IN  = 8;
  localparam int N_OUT = 8;
  localparam int V_W   = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       cpu_addr, cpu_wdata, cpu_rdata;
  logic             cpu_we, cpu_re, cpu_ready;
  logic [N_IN-1:0]  in_spikes;
  logic             in_valid, in_ready;
  logic [N_OUT-1:0] out_spikes;
  logic             out_valid, out_ready;
  logic [31:0]      step_count, spike_count, idle_cycles;

  always #5 clk = ~clk;

  neuro_lif_array #(.N_IN(N_IN), .N_OUT(N_OUT), .V_W(V_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .in_spikes(in_spikes), .in_valid(in_valid), .in_ready(in_ready),
    .out_spikes(out_spikes), .out_valid(out_valid), .out_ready(out_ready),
    .step_count(step_count), .spike_count(spike_count), .idle_cycles(idle_cycles)
  );

  typedef struct { bit chk; logic [7:0] val; string name; } rd_exp_t;
  rd_exp_t          rdq[$];
  logic [N_OUT-1:0] spq[$];
  rd_exp_t          mon_e;

  int tests = 0, fails = 0, n_acc = 0, n_rdy = 0;
  int exp_steps = 0, exp_spikes = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the next expectation whenever read data or an output vector is presented.
  always @(negedge clk) begin
    if (!rst && cpu_ready) begin
      n_rdy++;
      if (rdq.size() == 0) begin
        check32("cpu_ready unexpected pulse", 32'd1, 32'd0);
      end else begin
        mon_e = rdq.pop_front();
        if (mon_e.chk) check32(mon_e.name, 32'(cpu_rdata), 32'(mon_e.val));
      end
    end
    if (!rst && out_valid && out_ready) begin
      if (spq.size() == 0) check32("out_valid unexpected", 32'd1, 32'd0);
      else                 check32("out_spikes", 32'(out_spikes), 32'(spq.pop_front()));
    end
  end

  task automatic cpu_acc(input logic [7:0] a, input logic [7:0] d, input bit we, input bit re,
                         input logic [7:0] exp, input string name);
    rd_exp_t e;
    e.chk = re; e.val = exp; e.name = name;
    @(posedge clk); #1;
    cpu_addr = a; cpu_wdata = d; cpu_we = we; cpu_re = re;
    rdq.push_back(e);
    n_acc++;
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_re = 1'b0;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    cpu_acc(a, d, 1'b1, 1'b0, 8'd0, "wr");
  endtask

  task automatic cpu_rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    cpu_acc(a, 8'd0, 1'b0, 1'b1, exp, name);
  endtask

  task automatic load_row(input logic [7:0] o, input logic [7:0] v);
    cpu_wr(8'h05, 8'd0);
    cpu_wr(8'h06, o);
    repeat (N_IN) cpu_wr(8'h07, v);
  endtask

  task automatic zero_all();
    cpu_wr(8'h05, 8'd0);
    cpu_wr(8'h06, 8'd0);
    repeat (N_IN * N_OUT) cpu_wr(8'h07, 8'd0);
  endtask

  // One timestep: handshake, then measure cycles until out_valid (cycle T is the handshake cycle).
  task automatic run_step(input logic [N_IN-1:0] sp, input logic [N_OUT-1:0] exp, input string name);
    int n, lat;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check32({name, " in_ready"}, 32'(in_ready), 32'd1);
    if (!in_ready) return;
    in_spikes = sp; in_valid = 1'b1;
    spq.push_back(exp);
    exp_steps++;
    exp_spikes += $countones(exp);
    @(posedge clk); #1;
    in_valid = 1'b0; in_spikes = '0;
    lat = 1;
    while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    check32({name, " latency"}, 32'(lat), 32'(N_IN + 2));
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (got running, expected done)");
    $fatal(1);
  end

  initial begin
    int sc, ic, stable, ovc;
    rst = 1'b1; cpu_addr = 0; cpu_wdata = 0; cpu_we = 0; cpu_re = 0;
    in_spikes = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check32("rst in_ready", 32'(in_ready), 32'd0);
    check32("rst out_valid", 32'(out_valid), 32'd0);
    check32("rst step_count", step_count, 32'd0);
    check32("rst spike_count", spike_count, 32'd0);
    check32("rst idle_cycles", idle_cycles, 32'd0);
    check32("rst cpu_ready", 32'(cpu_ready), 32'd0);
    rst = 1'b0;
    cpu_rd(8'h02, 8'hC8, "THRESH reset");
    cpu_rd(8'h03, 8'h01, "LEAK reset");
    cpu_rd(8'h04, 8'h00, "REFRAC reset");
    cpu_rd(8'h00, 8'h00, "CTRL reset");
    cpu_rd(8'h01, 8'h00, "STATUS reset");
    @(posedge clk); #1;
    check32("cpu_ready single pulse", 32'(cpu_ready), 32'd0);

    // Weight pointer auto-increment, readback, out-of-range and simultaneous access
    cpu_wr(8'h05, 8'd7);
    cpu_wr(8'h06, 8'd0);
    cpu_wr(8'h07, 8'h10);
    cpu_wr(8'h07, 8'h10);
    cpu_rd(8'h05, 8'd1, "WSEL_IN after autoinc");
    cpu_rd(8'h06, 8'd1, "WSEL_OUT after autoinc");
    cpu_wr(8'h05, 8'd7);
    cpu_wr(8'h06, 8'd0);
    cpu_rd(8'h07, 8'h10, "w[0][7]");
    cpu_rd(8'h05, 8'd7, "WDATA read no increment");
    cpu_wr(8'h05, 8'd0);
    cpu_wr(8'h06, 8'd1);
    cpu_acc(8'h07, 8'h22, 1'b1, 1'b1, 8'h10, "w[1][0] rd+wr returns old");
    cpu_wr(8'h05, 8'd0);
    cpu_rd(8'h07, 8'h22, "w[1][0] after rd+wr");
    cpu_wr(8'h05, 8'd8);
    cpu_wr(8'h07, 8'h33);
    cpu_rd(8'h05, 8'd8, "WSEL_IN out of range no inc");
    cpu_rd(8'h07, 8'h00, "WDATA out of range read");

    // Single neuron fires from a full input vector
    zero_all();
    load_row(8'd3, 8'h40);
    cpu_wr(8'h00, 8'h03);
    run_step(8'hFF, 8'h08, "fire");
    check32("fire spike_count", spike_count, 32'd1);
    check32("fire step_count", step_count, 32'd1);

    // Leak: +50 per step, -1 leak: 49, 98, 147, 196, then 245 fires
    load_row(8'd3, 8'h00);
    cpu_wr(8'h05, 8'd0);
    cpu_wr(8'h06, 8'd0);
    cpu_wr(8'h07, 8'h32);
    cpu_wr(8'h00, 8'h03);
    for (int s = 0; s < 5; s++)
      run_step(8'h01, (s == 4) ? 8'h01 : 8'h00, $sformatf("leak step%0d", s + 1));

    // Refractory period 2: fires on steps 1, 4, 7
    cpu_wr(8'h04, 8'd2);
    load_row(8'd0, 8'h7F);
    cpu_wr(8'h00, 8'h03);
    for (int s = 0; s < 7; s++)
      run_step(8'hFF, (s % 3 == 0) ? 8'h01 : 8'h00, $sformatf("refrac step%0d", s + 1));

    // Negative saturation: -1024 per step must clamp at -2048, never wrap positive
    load_row(8'd0, 8'h00);
    load_row(8'd1, 8'h80);
    cpu_wr(8'h00, 8'h03);
    for (int s = 0; s < 6; s++)
      run_step(8'hFF, 8'h00, $sformatf("saturate step%0d", s + 1));

    // THRESH=0 fires every neuron even at zero membrane
    cpu_wr(8'h04, 8'd0);
    load_row(8'd1, 8'h00);
    cpu_wr(8'h02, 8'd0);
    cpu_wr(8'h00, 8'h03);
    run_step(8'h00, 8'hFF, "thresh0");
    cpu_wr(8'h02, 8'd200);

    // Backpressure: output held, busy write rejected with wr_err
    load_row(8'd2, 8'h40);
    cpu_wr(8'h00, 8'h03);
    out_ready = 1'b0;
    run_step(8'hFF, 8'h04, "backpressure");
    sc = int'(step_count);
    ic = int'(idle_cycles);
    stable = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid && out_spikes == 8'h04 && !in_ready) stable++;
    end
    check32("backpressure stable cycles", 32'(stable), 32'd20);
    check32("backpressure idle_cycles frozen", idle_cycles, 32'(ic));
    cpu_wr(8'h07, 8'h55);
    cpu_rd(8'h01, 8'h07, "STATUS busy+out_valid+wr_err");
    cpu_rd(8'h01, 8'h03, "STATUS wr_err cleared");
    cpu_rd(8'h05, 8'h00, "WSEL_IN unchanged by busy write");
    check32("backpressure step_count held", step_count, 32'(sc));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check32("backpressure step_count released", step_count, 32'(sc + 1));
    cpu_rd(8'h07, 8'h00, "w[3][0] unchanged by busy write");
    check32("total step_count", step_count, 32'(exp_steps));
    check32("total spike_count", spike_count, 32'(exp_spikes));

    // Disable: in_ready drops
    cpu_wr(8'h00, 8'h00);
    check32("disabled in_ready", 32'(in_ready), 32'd0);

    // Reset in the middle of a step discards it
    cpu_wr(8'h00, 8'h01);
    @(posedge clk); #1;
    in_spikes = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_spikes = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check32("midstep rst step_count", step_count, 32'd0);
    rst = 1'b0;
    ovc = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (out_valid) ovc++;
    end
    check32("midstep rst no output", 32'(ovc), 32'd0);
    check32("midstep rst in_ready", 32'(in_ready), 32'd0);
    cpu_rd(8'h02, 8'hC8, "THRESH after midstep rst");

    @(posedge clk); #1;
    check32("read queue drained", 32'(rdq.size()), 32'd0);
    check32("spike queue drained", 32'(spq.size()), 32'd0);
    check32("cpu_ready pulses per access", 32'(n_rdy), 32'(n_acc));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
